burst_memory_responder: RTL and testbench

Memory-side responder for the 64-bit, 4-beat physical-memory burst protocol driven by `cacheline_adaptor` through the `pmem_*` ports of the top level. It accepts one line-sized (256-bit) read or write request at a time, inserts a programmable number of wait states, then transfers the line as four 64-bit beats qualified by `pmem_resp`. It backs a synthesizable on-chip line store, so the full CPU/cache hierarchy can run on hardware or in simulation without an external memory model.

---
 rtl/burst_memory_responder.sv | 135 +++++++++++++
 tb/tb_burst_memory_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memory_responder.sv
// Line-store responder for the 4-beat, 64-bit pmem burst protocol.
// First beat comes a programmable number of wait states after acceptance; the requester holds its request for the whole transaction.
module burst_memory_responder #(
    parameter int unsigned LINE_IDX_BITS = 8,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        protocol_err
);
    localparam int unsigned DEPTH  = 1 << LINE_IDX_BITS;
    localparam logic [3:0]  RD_LAT = 4'(READ_LATENCY);
    localparam logic [3:0]  WR_LAT = 4'(WRITE_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [1:0]               beat_q, beat_d;
    logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
    logic                     wr_q, wr_d;
    logic                     err_q, err_d;
    logic                     resp_q, resp_d;
    logic [63:0]              rdata_q, rdata_d;
    logic [3:0]               lat;
    logic                     req_held;
    logic [LINE_IDX_BITS-1:0] addr_idx;
    logic                     unused_addr_bits;

    logic [3:0][63:0] mem_q [DEPTH];

    assign addr_idx         = pmem_address[5 +: LINE_IDX_BITS];
    assign unused_addr_bits = ^{pmem_address[31:5+LINE_IDX_BITS], pmem_address[4:0]};
    assign req_held         = wr_q ? pmem_write : pmem_read;
    assign lat              = pmem_write ? WR_LAT : RD_LAT;

    // The cycle after the last beat already shows resp low, so it doubles
    // as the turnaround cycle and the next request is sampled there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pmem_write || pmem_read) begin
                    wr_d  = pmem_write;
                    idx_d = addr_idx;
                    err_d = err_q | (pmem_write & pmem_read);
                    if (lat == 4'd0) begin
                        state_d = BURST;
                        beat_d  = 2'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = BURST;
                    beat_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (!req_held) begin
                    err_d = 1'b1;
                end
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        resp_d  = (state_d == BURST);
        rdata_d = '0;
        if ((state_d == BURST) && !wr_d) begin
            rdata_d = mem_q[idx_d][beat_d];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Write beats commit even when the request drops mid-burst.
    always_ff @(posedge clk) begin
        if ((state_q == BURST) && wr_q) begin
            mem_q[idx_q][beat_q] <= pmem_wdata;
        end
    end

    assign pmem_resp    = resp_q;
    assign pmem_rdata   = rdata_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_burst_memory_responder.sv
// Bench for burst_memory_responder: two instances (read/write latency 4/2 and 0/4)
// driven one at a time through per-instance request gating.
module tb_burst_memory_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_r, write_r;
    int          sel;
    logic [31:0] address;
    logic [63:0] wdata;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [63:0] rdata_a, rdata_b, rdata_s;
    logic        resp_a, resp_b, resp_s;
    logic        err_a, err_b, err_s;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;

    logic [255:0] mdl [int];
    logic [63:0]  exp_q [$];

    assign rd_a    = read_r  && (sel == 0);
    assign wr_a    = write_r && (sel == 0);
    assign rd_b    = read_r  && (sel == 1);
    assign wr_b    = write_r && (sel == 1);
    assign resp_s  = (sel == 1) ? resp_b  : resp_a;
    assign rdata_s = (sel == 1) ? rdata_b : rdata_a;
    assign err_s   = (sel == 1) ? err_b   : err_a;

    burst_memory_responder #(.LINE_IDX_BITS(8), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd_a), .pmem_write(wr_a),
        .pmem_address(address), .pmem_wdata(wdata), .pmem_rdata(rdata_a),
        .pmem_resp(resp_a), .protocol_err(err_a)
    );

    burst_memory_responder #(.LINE_IDX_BITS(8), .READ_LATENCY(0), .WRITE_LATENCY(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .pmem_read(rd_b), .pmem_write(wr_b),
        .pmem_address(address), .pmem_wdata(wdata), .pmem_rdata(rdata_b),
        .pmem_resp(resp_b), .protocol_err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic int key(input int s, input logic [31:0] a);
        return s * 1024 + int'(a[12:5]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        read_r  = 1'b0;
        write_r = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Requester: holds the request until the last beat, pushes expected read
    // beats to the scoreboard and pops/compares them as beats arrive.
    task automatic xfer(input int s, input bit wr, input bit both, input logic [31:0] addr,
                        input logic [255:0] line, output int lat, output int beats,
                        output bit clean, output int first_edge);
        int           cyc;
        int           base;
        logic [255:0] ln;
        logic [63:0]  exp_b;
        lat = -1; beats = 0; clean = 1'b1; first_edge = -1; cyc = 0;
        base    = cycle;
        sel     = s;
        address = addr;
        wdata   = line[63:0];
        if (wr) begin
            mdl[key(s, addr)] = line;
            write_r = 1'b1;
            read_r  = both;
        end else begin
            ln = mdl[key(s, addr)];
            for (int k = 0; k < 4; k++) exp_q.push_back(ln[64*k +: 64]);
            read_r = 1'b1;
        end
        while (beats < 4 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (resp_s) begin
                if (lat < 0) begin
                    lat        = cyc - 1;
                    first_edge = base + cyc;
                end
                if (wr) begin
                    wdata = line[64*beats +: 64];
                end else begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_beat%0d addr=%h: got %h, scoreboard empty", beats, addr, rdata_s);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (rdata_s !== exp_b) begin
                            n_fail++;
                            $display("FAIL rd_beat%0d addr=%h: got %h, expected %h", beats, addr, rdata_s, exp_b);
                        end
                    end
                end
                beats++;
            end else if (lat >= 0) begin
                clean = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        read_r  = 1'b0;
        write_r = 1'b0;
        @(negedge clk);
        if (resp_s) clean = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (resp_a !== 1'b0)   begin n_fail++; $display("FAIL reset_resp_a: got %b, expected 0", resp_a); end
        n_tests++; if (rdata_a !== 64'd0) begin n_fail++; $display("FAIL reset_rdata_a: got %h, expected 0", rdata_a); end
        n_tests++; if (err_a !== 1'b0)    begin n_fail++; $display("FAIL reset_err_a: got %b, expected 0", err_a); end
        n_tests++; if (resp_b !== 1'b0)   begin n_fail++; $display("FAIL reset_resp_b: got %b, expected 0", resp_b); end
        n_tests++; if (rdata_b !== 64'd0) begin n_fail++; $display("FAIL reset_rdata_b: got %h, expected 0", rdata_b); end
        n_tests++; if (err_b !== 1'b0)    begin n_fail++; $display("FAIL reset_err_b: got %b, expected 0", err_b); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, beats, fe; bit clean;
        logic [255:0] line;
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        xfer(0, 1'b1, 1'b0, 32'h0000_0100, line, lat, beats, clean, fe);
        n_tests++; if (lat !== 2)    begin n_fail++; $display("FAIL wr_latency: got %0d, expected 2", lat); end
        n_tests++; if (beats !== 4)  begin n_fail++; $display("FAIL wr_beats: got %0d, expected 4", beats); end
        n_tests++; if (clean !== 1)  begin n_fail++; $display("FAIL wr_resp_contiguous: got %b, expected 1", clean); end
        xfer(0, 1'b0, 1'b0, 32'h0000_0100, '0, lat, beats, clean, fe);
        n_tests++; if (lat !== 4)    begin n_fail++; $display("FAIL rd_latency: got %0d, expected 4", lat); end
        n_tests++; if (beats !== 4)  begin n_fail++; $display("FAIL rd_beats: got %0d, expected 4", beats); end
        n_tests++; if (clean !== 1)  begin n_fail++; $display("FAIL rd_resp_contiguous: got %b, expected 1", clean); end
    endtask

    task automatic test_latency0();
        int lat, beats, fe1, fe2; bit clean;
        logic [255:0] line;
        line = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        xfer(1, 1'b1, 1'b0, 32'h0000_0300, line, lat, beats, clean, fe1);
        n_tests++; if (lat !== 4)    begin n_fail++; $display("FAIL b_wr_latency: got %0d, expected 4", lat); end
        xfer(1, 1'b0, 1'b0, 32'h0000_0300, '0, lat, beats, clean, fe1);
        n_tests++; if (lat !== 0)    begin n_fail++; $display("FAIL lat0_first: got %0d, expected 0", lat); end
        n_tests++; if (clean !== 1)  begin n_fail++; $display("FAIL lat0_contiguous: got %b, expected 1", clean); end
        xfer(1, 1'b0, 1'b0, 32'h0000_0300, '0, lat, beats, clean, fe2);
        n_tests++; if (lat !== 0)    begin n_fail++; $display("FAIL lat0_second: got %0d, expected 0", lat); end
        n_tests++; if (fe2 - fe1 !== 5) begin n_fail++; $display("FAIL lat0_cadence: got %0d cycles, expected 5", fe2 - fe1); end
    endtask

    task automatic test_alias();
        int lat, beats, fe; bit clean;
        logic [255:0] line;
        line = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
        xfer(0, 1'b1, 1'b0, 32'h0000_2000, line, lat, beats, clean, fe);
        xfer(0, 1'b0, 1'b0, 32'h0000_0000, '0, lat, beats, clean, fe);
        n_tests++; if (beats !== 4) begin n_fail++; $display("FAIL alias_beats: got %0d, expected 4", beats); end
    endtask

    task automatic test_abort_wait();
        int lat, beats, fe, nr; bit clean;
        logic [255:0] line;
        do_reset();
        line = {64'h5555_0000_0000_0044, 64'h5555_0000_0000_0033,
                64'h5555_0000_0000_0022, 64'h5555_0000_0000_0011};
        xfer(1, 1'b1, 1'b0, 32'h0000_0500, line, lat, beats, clean, fe);
        sel = 1; address = 32'h0000_0500; wdata = 64'hBAD0_BAD0_BAD0_BAD0;
        write_r = 1'b1;
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            if (i == 2) begin #1; write_r = 1'b0; end
            @(negedge clk);
            if (resp_s) nr++;
        end
        n_tests++; if (nr !== 0)      begin n_fail++; $display("FAIL abort_resp: got %0d beats, expected 0", nr); end
        n_tests++; if (err_s !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b, expected 0", err_s); end
        xfer(1, 1'b0, 1'b0, 32'h0000_0500, '0, lat, beats, clean, fe);
        n_tests++; if (beats !== 4)   begin n_fail++; $display("FAIL abort_readback_beats: got %0d, expected 4", beats); end
    endtask

    task automatic test_violation();
        int lat, beats, fe, nb, cyc; bit clean;
        logic [255:0] line;
        do_reset();
        line = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        xfer(0, 1'b1, 1'b1, 32'h0000_0440, line, lat, beats, clean, fe);
        n_tests++; if (lat !== 2)      begin n_fail++; $display("FAIL both_as_write_latency: got %0d, expected 2", lat); end
        n_tests++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b, expected 1", err_a); end
        xfer(0, 1'b0, 1'b0, 32'h0000_0440, '0, lat, beats, clean, fe);

        do_reset();
        n_tests++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b, expected 0", err_a); end
        sel = 0; address = 32'h0000_0440; read_r = 1'b1;
        nb = 0; cyc = 0;
        while (nb < 4 && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (resp_s) begin
                nb++;
                if (nb == 2) read_r = 1'b0;
            end
        end
        read_r = 1'b0;
        @(negedge clk);
        n_tests++; if (nb !== 4)       begin n_fail++; $display("FAIL drop_beats: got %0d, expected 4", nb); end
        n_tests++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b, expected 1", err_a); end
        n_tests++; if (resp_a !== 1'b0) begin n_fail++; $display("FAIL drop_resp_after: got %b, expected 0", resp_a); end
        xfer(0, 1'b0, 1'b0, 32'h0000_0440, '0, lat, beats, clean, fe);
        n_tests++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, expected 1", err_a); end
    endtask

    task automatic test_reset_mid_burst();
        int lat, beats, fe, nb, cyc; bit clean;
        sel = 0; address = 32'h0000_0100; read_r = 1'b1;
        nb = 0; cyc = 0;
        while (nb < 2 && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (resp_s) nb++;
        end
        n_tests++; if (nb !== 2) begin n_fail++; $display("FAIL midrst_reach_beat1: got %0d beats, expected 2", nb); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (resp_a !== 1'b0)   begin n_fail++; $display("FAIL midrst_resp: got %b, expected 0", resp_a); end
        n_tests++; if (rdata_a !== 64'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h, expected 0", rdata_a); end
        n_tests++; if (err_a !== 1'b0)    begin n_fail++; $display("FAIL midrst_err: got %b, expected 0", err_a); end
        read_r = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        xfer(0, 1'b0, 1'b0, 32'h0000_0100, '0, lat, beats, clean, fe);
        n_tests++; if (lat !== 4)   begin n_fail++; $display("FAIL postrst_latency: got %0d, expected 4", lat); end
        n_tests++; if (beats !== 4) begin n_fail++; $display("FAIL postrst_beats: got %0d, expected 4", beats); end
    endtask

    initial begin
        reset_n = 1'b0;
        read_r  = 1'b0;
        write_r = 1'b0;
        sel     = 0;
        address = '0;
        wdata   = '0;
        test_reset();
        test_write_read();
        test_latency0();
        test_alias();
        test_abort_wait();
        test_violation();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
